// File: rtl/lp_pkg.sv
// Shared constants and types for the simplex pivot-column search.
// Sizes, FSM encoding and the fp32 exponent marker for NaN/Inf.
package lp_pkg;

  localparam int DATAW = 32;
  localparam int IDXW  = 16;
  localparam int EXPW  = 8;

  localparam logic [EXPW-1:0] EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    DECIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/find_pivot_col_if.sv
// Objective-row stream bundle (valid/ready) with master/slave views.
// Tied to the flat DUT ports by whoever instantiates it.
interface find_pivot_col_if #(
    parameter int DATAW = lp_pkg::DATAW
);

    logic [DATAW-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/fp32_neg_mag_cmp.sv
// Eligibility and magnitude compare of one fp32 candidate
// against the most negative value held so far.
module fp32_neg_mag_cmp
    import lp_pkg::*;
#(
    parameter int DATAW = lp_pkg::DATAW
) (
    input  logic [DATAW-1:0] cand,
    input  logic [DATAW-2:0] best_mag,
    input  logic             have_best,
    output logic             eligible,
    output logic             take,
    output logic             nonfinite
);

    logic [DATAW-2:0] mag;
    logic [EXPW-1:0]  expo;

    assign mag       = cand[DATAW-2:0];
    assign expo      = cand[DATAW-2 -: EXPW];
    assign nonfinite = (expo == EXP_ONES);

    // -0.0 has sign set but zero magnitude and must not qualify
    assign eligible = cand[DATAW-1] && (|mag);

    // Strict greater keeps the earlier index on ties
    assign take = eligible && (!have_best || (mag > best_mag));

endmodule

// File: rtl/find_pivot_col.sv
// Streams the objective row and picks the most negative coefficient
// as the entering column, or flags optimal/error termination.
module find_pivot_col #(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0]      num_cols,
    input  logic [DATAW-1:0] S_AXIS_OBJROW_TDATA,
    input  logic             S_AXIS_OBJROW_TVALID,
    output logic             S_AXIS_OBJROW_TREADY,
    output logic [15:0]      pivot_col,
    output logic [DATAW-1:0] pivot_val,
    output logic             cont,
    output logic             terminate,
    output logic             error
);

    import lp_pkg::*;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  best_idx_q, best_idx_d;
    logic [DATAW-1:0] best_val_q, best_val_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic [IDXW-1:0]  pivot_col_q, pivot_col_d;
    logic [DATAW-1:0] pivot_val_q, pivot_val_d;
    logic             cont_q, cont_d;
    logic             term_q, term_d;
    logic             error_q, error_d;

    logic cols_ok, beat, last, is_cand;
    logic elig, take, nonfin;

    assign cols_ok = (num_cols >= 16'd2);
    assign S_AXIS_OBJROW_TREADY = (state_q == SCAN) && resetn && cols_ok;
    assign beat    = S_AXIS_OBJROW_TVALID && S_AXIS_OBJROW_TREADY;
    assign last    = (cnt_q == num_cols - 16'd1);
    assign is_cand = (cnt_q < num_cols - 16'd1);

    fp32_neg_mag_cmp #(.DATAW(DATAW)) u_cmp (
        .cand      (S_AXIS_OBJROW_TDATA),
        .best_mag  (best_val_q[DATAW-2:0]),
        .have_best (found_q),
        .eligible  (elig),
        .take      (take),
        .nonfinite (nonfin)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        found_d     = found_q;
        err_d       = err_q;
        pivot_col_d = pivot_col_q;
        pivot_val_d = pivot_val_q;
        cont_d      = cont_q;
        term_d      = term_q;
        error_d     = error_q;
        unique case (state_q)
            SCAN: begin
                if (!cols_ok) begin
                    term_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (beat) begin
                    cnt_d = cnt_q + 16'd1;
                    if (nonfin) err_d = 1'b1;
                    if (is_cand && take) begin
                        best_val_d = S_AXIS_OBJROW_TDATA;
                        best_idx_d = cnt_q;
                        found_d    = 1'b1;
                    end
                    if (last) state_d = DECIDE;
                end
            end
            DECIDE: begin
                state_d = DONE;
                if (err_q) begin
                    term_d  = 1'b1;
                    error_d = 1'b1;
                end else if (found_q) begin
                    cont_d      = 1'b1;
                    pivot_col_d = best_idx_q;
                    pivot_val_d = best_val_q;
                end else begin
                    term_d = 1'b1;
                end
            end
            DONE: begin
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            found_q     <= 1'b0;
            err_q       <= 1'b0;
            pivot_col_q <= '0;
            pivot_val_q <= '0;
            cont_q      <= 1'b0;
            term_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            found_q     <= found_d;
            err_q       <= err_d;
            pivot_col_q <= pivot_col_d;
            pivot_val_q <= pivot_val_d;
            cont_q      <= cont_d;
            term_q      <= term_d;
            error_q     <= error_d;
        end
    end

    assign pivot_col = pivot_col_q;
    assign pivot_val = pivot_val_q;
    assign cont      = cont_q;
    assign terminate = term_q;
    assign error     = error_q;

endmodule

// File: doc/find_pivot_col.md
FIND_PIVOT_COL -- requirements
Module: find_pivot_col

Interface
- REQ-001 SHALL have parameter DATAW, default 32, meaning bit width of one tableau element (IEEE-754 single).
- REQ-002 SHALL have port clk  input  1  meaning sole clock, rising edge.
- REQ-003 SHALL have port resetn  input  1  meaning reset, asynchronous, active-low.
- REQ-004 SHALL have port num_cols  input  16  meaning tableau width, with the last column being RHS; stable from reset release until done.
- REQ-005 SHALL have port S_AXIS_OBJROW_TDATA  input  DATAW  meaning objective-row element, streamed in column order.
- REQ-006 SHALL have port S_AXIS_OBJROW_TVALID  input  1  meaning upstream data valid.
- REQ-007 SHALL have port S_AXIS_OBJROW_TREADY  output  1  meaning block accepts a beat.
- REQ-008 SHALL have port pivot_col  output  16  meaning index of the chosen entering column.
- REQ-009 SHALL have port pivot_val  output  DATAW  meaning objective coefficient at pivot_col.
- REQ-010 SHALL have port cont  output  1  meaning pivot found, next stage may run.
- REQ-011 SHALL have port terminate  output  1  meaning no pivot: optimal or error.
- REQ-012 SHALL have port error  output  1  meaning terminate was caused by NaN/Inf input or illegal num_cols.

Function
- REQ-013 SHALL use FSM states SCAN, DECIDE, DONE; reset enters SCAN.
- REQ-014 SHALL drive TREADY = (state==SCAN) && resetn && (num_cols>=2); beat accepted when TVALID&&TREADY.
- REQ-015 SHALL keep a 16-bit beat counter, cleared on reset, incremented per accepted beat.
- REQ-016 SHALL treat beats 0..num_cols-2 as candidates; the RHS beat (num_cols-1) is accepted but never a candidate.
- REQ-017 SHALL make a candidate eligible only if strictly negative (sign=1, magnitude nonzero); -0.0 and positives are ineligible.
- REQ-018 SHALL compare eligible values by magnitude bits [30:0] as unsigned; larger magnitude = more negative and replaces the held minimum.
- REQ-019 SHALL keep the earlier index on equal magnitude (lowest index wins).
- REQ-020 SHALL set a sticky error flag on any accepted beat with exponent 0xFF (NaN/Inf), including the RHS beat.
- REQ-021 SHALL go SCAN->DECIDE at the edge accepting beat num_cols-1, and DECIDE->DONE on the next edge.
- REQ-022 SHALL, on the DECIDE->DONE edge: if error flag set, terminate=1, error=1; else if an eligible candidate exists, cont=1 with pivot_col/pivot_val holding it; else terminate=1, error=0.
- REQ-023 SHALL make cont and terminate mutually exclusive and hold them until reset.
- REQ-024 SHALL give cont/terminate a latency of exactly 1 cycle after the last-beat handshake edge.
- REQ-025 SHALL, if num_cols<2, accept no beats and assert terminate=1, error=1 on the first edge after reset release.
- REQ-026 SHALL ignore TVALID in DECIDE and DONE.
- REQ-027 SHALL keep pivot_col/pivot_val undefined-but-stable when cont=0; the bench checks them only with cont=1.

Reset
- REQ-028 SHALL, with resetn low, immediately force cont=0, terminate=0, error=0, pivot_col=0, pivot_val=0, counter=0, state=SCAN, TREADY=0.
- REQ-029 SHALL, on reset mid-scan, discard all partial results; the next scan starts at beat 0.

Structure
- REQ-030 SHALL place DATAW, index width 16, the state encoding and the FP exponent-all-ones constant in shared package lp_pkg.
- REQ-031 SHALL place the combinational eligibility/magnitude compare in sub-module fp32_neg_mag_cmp.

Verification
- REQ-032 SHALL cover: num_cols=4, beats 0x40000000, 0xBF800000, 0xC0400000, 0x41200000 -> cont=1, pivot_col=2, pivot_val=0xC0400000, one cycle after beat 3.
- REQ-033 SHALL cover: num_cols=3, beats 0x3F800000, 0x80000000, 0xC0000000 (RHS) -> terminate=1, error=0, cont=0.
- REQ-034 SHALL cover: num_cols=4, beats 0xBF800000, 0xC0000000, 0xC0000000, 0 -> cont=1, pivot_col=1.
- REQ-035 SHALL cover: num_cols=3, beat1=0x7FC00000 -> terminate=1, error=1.
- REQ-036 SHALL cover: random TVALID gaps, resetn pulsed low after 2 of 5 beats, then full row -> result reflects only post-reset row, TREADY low during reset.
- REQ-037 SHALL cover: num_cols=1 -> TREADY never high, terminate=1, error=1 one cycle after reset release.
